// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register for the five-stage core: captures decoded ID fields, forwards
// operands from EX/MEM and MEM/WB, and inserts bubbles on load-use hazards and branch flush.
module ex_operand_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [2:0]        id_alu_ctrl,
  input  logic              id_alu_src_imm,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              id_branch,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [4:0]        exmem_rd,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic              memwb_reg_write,
  input  logic [4:0]        memwb_rd,
  input  logic [XLEN-1:0]   memwb_data,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_alu_a,
  output logic [XLEN-1:0]   ex_alu_b,
  output logic [2:0]        ex_alu_ctrl,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [4:0]        ex_rd,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_branch,
  output logic [PERF_W-1:0] perf_bubbles
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [4:0]        rd_q, rd_d;
  logic [2:0]        alu_ctrl_q, alu_ctrl_d;
  logic              src_imm_q, src_imm_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              reg_write_q, reg_write_d;
  logic              branch_q, branch_d;
  logic [PERF_W-1:0] perf_q, perf_d;

  logic hz;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // Load in EX whose result the ID instruction needs; x0 loads never stall.
  assign hz = valid_q & mem_read_q & (rd_q != 5'd0) & id_valid &
              ((id_use_rs1 & (id_rs1 == rd_q)) | (id_use_rs2 & (id_rs2 == rd_q)));

  assign stall_id = hz & ~flush;

  always_comb begin
    valid_d     = id_valid;
    pc_d        = id_pc;
    rs1_data_d  = id_rs1_data;
    rs2_data_d  = id_rs2_data;
    imm_d       = id_imm;
    rs1_d       = id_rs1;
    rs2_d       = id_rs2;
    rd_d        = id_rd;
    alu_ctrl_d  = id_alu_ctrl;
    src_imm_d   = id_alu_src_imm;
    mem_read_d  = id_mem_read & id_valid;
    mem_write_d = id_mem_write & id_valid;
    reg_write_d = id_reg_write & id_valid;
    branch_d    = id_branch & id_valid;
    if (flush || hz) begin
      valid_d     = 1'b0;
      rd_d        = 5'd0;
      alu_ctrl_d  = 3'b000;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      reg_write_d = 1'b0;
      branch_d    = 1'b0;
    end
  end

  // Only hazard bubbles are counted; a flush takes precedence and is not.
  always_comb begin
    perf_d = perf_q;
    if (hz && !flush && (perf_q != {PERF_W{1'b1}})) begin
      perf_d = perf_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      rd_q        <= 5'd0;
      alu_ctrl_q  <= 3'b000;
      src_imm_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      branch_q    <= 1'b0;
      perf_q      <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alu_ctrl_q  <= alu_ctrl_d;
      src_imm_q   <= src_imm_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      branch_q    <= branch_d;
      perf_q      <= perf_d;
    end
  end

  function automatic logic [XLEN-1:0] fwd(input logic [4:0] idx, input logic [XLEN-1:0] rf);
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == idx)) begin
      return exmem_result;
    end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == idx)) begin
      return memwb_data;
    end
    return rf;
  endfunction

  always_comb begin
    fwd_rs1 = fwd(rs1_q, rs1_data_q);
    fwd_rs2 = fwd(rs2_q, rs2_data_q);
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_alu_a      = fwd_rs1;
  assign ex_alu_b      = src_imm_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_alu_ctrl   = alu_ctrl_q;
  assign ex_rd         = rd_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_branch     = branch_q;
  assign perf_bubbles  = perf_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: vector table for capture/forwarding plus hand sequences
// for reset, load-use stall, x0, flush and bubble-counter saturation.
module tb_ex_operand_stage;

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        use1, use2;
    logic [2:0]  ctrl;
    logic        src_imm;
    logic [3:0]  ctl;  // {mem_read, mem_write, reg_write, branch}
    logic        xm_we;
    logic [4:0]  xm_rd;
    logic [31:0] xm_res;
    logic        mw_we;
    logic [4:0]  mw_rd;
    logic [31:0] mw_dat;
    logic        flush;
  } in_t;

  typedef struct {
    in_t         i;
    logic        e_valid;
    logic [31:0] e_a, e_b, e_st;
    logic [2:0]  e_ctrl;
    logic [4:0]  e_rd;
    logic [3:0]  e_ctl;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_use_rs1, id_use_rs2, id_alu_src_imm;
  logic id_mem_read, id_mem_write, id_reg_write, id_branch, flush;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, exmem_result, memwb_data;
  logic [4:0] id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd;
  logic [2:0] id_alu_ctrl;
  logic exmem_reg_write, memwb_reg_write;

  logic stall_id, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch;
  logic [31:0] ex_pc, ex_alu_a, ex_alu_b, ex_store_data;
  logic [2:0] ex_alu_ctrl;
  logic [4:0] ex_rd;
  logic [15:0] perf_bubbles;

  logic s_stall, s_valid, s_mr, s_mw, s_rw, s_br;
  logic [31:0] s_pc, s_a, s_b, s_st;
  logic [2:0] s_ctrl;
  logic [4:0] s_rd;
  logic [2:0] s_perf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(32), .PERF_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_alu_ctrl(id_alu_ctrl),
    .id_alu_src_imm(id_alu_src_imm), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_branch(id_branch), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_a(ex_alu_a),
    .ex_alu_b(ex_alu_b), .ex_alu_ctrl(ex_alu_ctrl), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_branch(ex_branch), .perf_bubbles(perf_bubbles)
  );

  // Narrow counter copy so saturation is reachable in a few cycles.
  ex_operand_stage #(.XLEN(32), .PERF_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_alu_ctrl(id_alu_ctrl),
    .id_alu_src_imm(id_alu_src_imm), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_branch(id_branch), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .stall_id(s_stall), .ex_valid(s_valid), .ex_pc(s_pc), .ex_alu_a(s_a),
    .ex_alu_b(s_b), .ex_alu_ctrl(s_ctrl), .ex_store_data(s_st),
    .ex_rd(s_rd), .ex_mem_read(s_mr), .ex_mem_write(s_mw),
    .ex_reg_write(s_rw), .ex_branch(s_br), .perf_bubbles(s_perf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic in_t mk(input logic valid, input logic [31:0] pc, rs1d, rs2d, imm,
                             input logic [4:0] rs1, rs2, rd, input logic use1, use2,
                             input logic [2:0] ctrl, input logic src_imm, input logic [3:0] ctl,
                             input logic xm_we, input logic [4:0] xm_rd, input logic [31:0] xm_res,
                             input logic mw_we, input logic [4:0] mw_rd,
                             input logic [31:0] mw_dat);
    in_t r;
    r.valid = valid; r.pc = pc; r.rs1d = rs1d; r.rs2d = rs2d; r.imm = imm;
    r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.use1 = use1; r.use2 = use2;
    r.ctrl = ctrl; r.src_imm = src_imm; r.ctl = ctl;
    r.xm_we = xm_we; r.xm_rd = xm_rd; r.xm_res = xm_res;
    r.mw_we = mw_we; r.mw_rd = mw_rd; r.mw_dat = mw_dat; r.flush = 1'b0;
    return r;
  endfunction

  task automatic drive(input in_t v);
    id_valid = v.valid; id_pc = v.pc; id_rs1_data = v.rs1d; id_rs2_data = v.rs2d;
    id_imm = v.imm; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    id_use_rs1 = v.use1; id_use_rs2 = v.use2; id_alu_ctrl = v.ctrl;
    id_alu_src_imm = v.src_imm;
    {id_mem_read, id_mem_write, id_reg_write, id_branch} = v.ctl;
    exmem_reg_write = v.xm_we; exmem_rd = v.xm_rd; exmem_result = v.xm_res;
    memwb_reg_write = v.mw_we; memwb_rd = v.mw_rd; memwb_data = v.mw_dat;
    flush = v.flush;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  vec_t vecs[8];
  in_t nop, lw5, rd5, t;

  initial begin
    // pc rs1d rs2d imm rs1 rs2 rd u1 u2 ctrl src ctl | exmem we rd res | memwb we rd data
    vecs[0].i = mk(1, 32'h100, 32'h5, 32'h7, 32'h0, 1, 2, 3, 1, 1, 3'b000, 0, 4'b0010,
                   0, 0, 0, 0, 0, 0);
    vecs[0].e_valid = 1; vecs[0].e_a = 32'h5; vecs[0].e_b = 32'h7; vecs[0].e_st = 32'h7;
    vecs[0].e_ctrl = 3'b000; vecs[0].e_rd = 3; vecs[0].e_ctl = 4'b0010;
    vecs[1].i = mk(1, 32'h104, 32'h1111, 32'h22, 32'h0, 3, 1, 4, 1, 1, 3'b001, 0, 4'b0010,
                   1, 3, 32'h10, 1, 3, 32'h99);
    vecs[1].e_valid = 1; vecs[1].e_a = 32'h10; vecs[1].e_b = 32'h22; vecs[1].e_st = 32'h22;
    vecs[1].e_ctrl = 3'b001; vecs[1].e_rd = 4; vecs[1].e_ctl = 4'b0010;
    vecs[2].i = mk(1, 32'h108, 32'h1111, 32'h22, 32'h0, 3, 1, 4, 1, 1, 3'b001, 0, 4'b0010,
                   1, 0, 32'h10, 0, 3, 32'h99);
    vecs[2].e_valid = 1; vecs[2].e_a = 32'h1111; vecs[2].e_b = 32'h22; vecs[2].e_st = 32'h22;
    vecs[2].e_ctrl = 3'b001; vecs[2].e_rd = 4; vecs[2].e_ctl = 4'b0010;
    vecs[3].i = mk(1, 32'h10c, 32'h1111, 32'h22, 32'h0, 3, 1, 4, 1, 1, 3'b001, 0, 4'b0010,
                   1, 0, 32'h10, 1, 3, 32'h99);
    vecs[3].e_valid = 1; vecs[3].e_a = 32'h99; vecs[3].e_b = 32'h22; vecs[3].e_st = 32'h22;
    vecs[3].e_ctrl = 3'b001; vecs[3].e_rd = 4; vecs[3].e_ctl = 4'b0010;
    vecs[4].i = mk(1, 32'h110, 32'h40, 32'h33, 32'hc, 8, 9, 10, 1, 1, 3'b010, 1, 4'b0010,
                   1, 8, 32'hAA, 1, 9, 32'hBB);
    vecs[4].e_valid = 1; vecs[4].e_a = 32'hAA; vecs[4].e_b = 32'hc; vecs[4].e_st = 32'hBB;
    vecs[4].e_ctrl = 3'b010; vecs[4].e_rd = 10; vecs[4].e_ctl = 4'b0010;
    vecs[5].i = mk(0, 32'h114, 32'h1, 32'h2, 32'h0, 11, 12, 13, 1, 1, 3'b110, 0, 4'b1111,
                   0, 0, 0, 0, 0, 0);
    vecs[5].e_valid = 0; vecs[5].e_a = 32'h1; vecs[5].e_b = 32'h2; vecs[5].e_st = 32'h2;
    vecs[5].e_ctrl = 3'b110; vecs[5].e_rd = 13; vecs[5].e_ctl = 4'b0000;
    vecs[6].i = mk(1, 32'h118, 32'h300, 32'h1, 32'h8, 2, 7, 0, 1, 1, 3'b000, 1, 4'b0100,
                   1, 7, 32'h55, 0, 0, 0);
    vecs[6].e_valid = 1; vecs[6].e_a = 32'h300; vecs[6].e_b = 32'h8; vecs[6].e_st = 32'h55;
    vecs[6].e_ctrl = 3'b000; vecs[6].e_rd = 0; vecs[6].e_ctl = 4'b0100;
    vecs[7].i = mk(1, 32'h11c, 32'h1234, 32'h5678, 32'h0, 0, 0, 14, 1, 1, 3'b011, 0, 4'b0011,
                   1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
    vecs[7].e_valid = 1; vecs[7].e_a = 32'h1234; vecs[7].e_b = 32'h5678; vecs[7].e_st = 32'h5678;
    vecs[7].e_ctrl = 3'b011; vecs[7].e_rd = 14; vecs[7].e_ctl = 4'b0011;

    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    lw5 = mk(1, 32'h200, 32'h1000, 0, 0, 1, 0, 5, 1, 0, 3'b000, 1, 4'b1010, 0, 0, 0, 0, 0, 0);
    rd5 = mk(1, 32'h204, 32'h0, 0, 32'h4, 5, 0, 6, 1, 0, 3'b000, 1, 4'b0010, 0, 0, 0, 0, 0, 0);

    drive(nop);
    #2;
    check("reset_valid", {31'b0, ex_valid}, 0);
    check("reset_alu_a", ex_alu_a, 0);
    check("reset_stall", {31'b0, stall_id}, 0);
    do_reset();
    check("post_reset_pc", ex_pc, 0);
    check("post_reset_perf", {16'b0, perf_bubbles}, 0);
    check("post_reset_ctl", {28'b0, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch}, 0);

    for (int k = 0; k < 8; k++) begin
      drive(vecs[k].i);
      step();
      check($sformatf("v%0d_valid", k), {31'b0, ex_valid}, {31'b0, vecs[k].e_valid});
      check($sformatf("v%0d_pc", k), ex_pc, vecs[k].i.pc);
      check($sformatf("v%0d_a", k), ex_alu_a, vecs[k].e_a);
      check($sformatf("v%0d_b", k), ex_alu_b, vecs[k].e_b);
      check($sformatf("v%0d_store", k), ex_store_data, vecs[k].e_st);
      check($sformatf("v%0d_ctrl", k), {29'b0, ex_alu_ctrl}, {29'b0, vecs[k].e_ctrl});
      check($sformatf("v%0d_rd", k), {27'b0, ex_rd}, {27'b0, vecs[k].e_rd});
      check($sformatf("v%0d_ctl", k),
            {28'b0, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch},
            {28'b0, vecs[k].e_ctl});
      check($sformatf("v%0d_stall", k), {31'b0, stall_id}, 0);
    end

    // Asynchronous reset with a live instruction in EX.
    drive(vecs[0].i);
    step();
    check("pre_async_valid", {31'b0, ex_valid}, 1);
    drive(nop);
    #1 rst_n = 1'b0;
    #1;
    check("async_valid", {31'b0, ex_valid}, 0);
    check("async_pc", ex_pc, 0);
    check("async_a", ex_alu_a, 0);
    check("async_b", ex_alu_b, 0);
    check("async_store", ex_store_data, 0);
    check("async_rd", {27'b0, ex_rd}, 0);
    check("async_ctl", {28'b0, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Load-use: one stall cycle, one counted bubble, then MEM/WB forwarding.
    do_reset();
    drive(lw5);
    step();
    check("lu_load_in_ex", {31'b0, ex_mem_read}, 1);
    drive(rd5);
    #1;
    check("lu_stall", {31'b0, stall_id}, 1);
    step();
    check("lu_bubble_valid", {31'b0, ex_valid}, 0);
    check("lu_bubble_ctl", {28'b0, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch}, 0);
    check("lu_perf", {16'b0, perf_bubbles}, 1);
    check("lu_stall_cleared", {31'b0, stall_id}, 0);
    t = rd5; t.mw_we = 1; t.mw_rd = 5; t.mw_dat = 32'hABCD;
    drive(t);
    step();
    check("lu_fwd_valid", {31'b0, ex_valid}, 1);
    check("lu_fwd_a", ex_alu_a, 32'hABCD);
    check("lu_fwd_b", ex_alu_b, 32'h4);
    check("lu_perf_hold", {16'b0, perf_bubbles}, 1);

    // Reset while stalled clears the stall at once.
    do_reset();
    drive(lw5);
    step();
    drive(rd5);
    #1;
    check("rs_stall_before", {31'b0, stall_id}, 1);
    rst_n = 1'b0;
    #1;
    check("rs_stall_after", {31'b0, stall_id}, 0);
    check("rs_valid_after", {31'b0, ex_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Load to x0 never stalls and x0 is never forwarded.
    do_reset();
    t = lw5; t.rd = 0;
    drive(t);
    step();
    t = rd5; t.rs1 = 0; t.rs1d = 32'h777; t.xm_we = 1; t.xm_rd = 0; t.xm_res = 32'hDEAD;
    t.mw_we = 1; t.mw_rd = 0; t.mw_dat = 32'hBEEF;
    drive(t);
    #1;
    check("x0_stall", {31'b0, stall_id}, 0);
    step();
    check("x0_valid", {31'b0, ex_valid}, 1);
    check("x0_no_fwd", ex_alu_a, 32'h777);
    check("x0_perf", {16'b0, perf_bubbles}, 0);

    // Flush during a load-use hazard: flush wins, bubble not counted.
    do_reset();
    drive(lw5);
    step();
    t = rd5; t.flush = 1; t.ctrl = 3'b101; t.ctl = 4'b1111;
    drive(t);
    #1;
    check("fl_stall", {31'b0, stall_id}, 0);
    step();
    check("fl_valid", {31'b0, ex_valid}, 0);
    check("fl_ctl", {28'b0, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch}, 0);
    check("fl_alu_ctrl", {29'b0, ex_alu_ctrl}, 0);
    check("fl_perf", {16'b0, perf_bubbles}, 0);

    // Repeated hazards: the 3-bit counter saturates at all-ones, the 16-bit one keeps counting.
    do_reset();
    for (int n = 0; n < 9; n++) begin
      drive(lw5);
      step();
      drive(rd5);
      step();
      if (n == 6) check("sat_at_7", {29'b0, s_perf}, 7);
    end
    check("sat_hold", {29'b0, s_perf}, 7);
    check("wide_count", {16'b0, perf_bubbles}, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register with operand forwarding and load-use hazard detection for the five-stage RISC-V core. It captures decoded instructions from ID and drives the execute-stage ALU's `inputA`, `inputB` and 3-bit `control` directly. It resolves RAW dependencies by forwarding from EX/MEM and MEM/WB. It stalls ID and inserts a bubble on load-use, and squashes on branch flush.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `PERF_W`, 16, width of the bubble counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `id_valid`  in  1  ID holds a real instruction.
- `id_pc`  in  XLEN  PC of the ID instruction.
- `id_rs1_data`, `id_rs2_data`  in  XLEN  register-file read data.
- `id_imm`  in  XLEN  sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd`  in  5  register indices.
- `id_use_rs1`, `id_use_rs2`  in  1  instruction actually reads rs1/rs2.
- `id_alu_ctrl`  in  3  ALU operation code.
- `id_alu_src_imm`  in  1  operand B = immediate.
- `id_mem_read`, `id_mem_write`, `id_reg_write`, `id_branch`  in  1  stage controls.
- `flush`  in  1  branch taken; squash the ID instruction.
- `exmem_reg_write`  in  1  EX/MEM writes a register (already valid-gated).
- `exmem_rd`  in  5  EX/MEM destination.
- `exmem_result`  in  XLEN  EX/MEM ALU result.
- `memwb_reg_write`  in  1  MEM/WB writes a register.
- `memwb_rd`  in  5  MEM/WB destination.
- `memwb_data`  in  XLEN  MEM/WB writeback value.
- `stall_id`  out  1  hold PC and IF/ID this cycle.
- `ex_valid`  out  1  EX holds a real instruction.
- `ex_pc`  out  XLEN  PC of the EX instruction.
- `ex_alu_a`, `ex_alu_b`  out  XLEN  ALU operands.
- `ex_alu_ctrl`  out  3  ALU operation code.
- `ex_store_data`  out  XLEN  forwarded rs2 value for stores.
- `ex_rd`  out  5  EX destination.
- `ex_mem_read`, `ex_mem_write`, `ex_reg_write`, `ex_branch`  out  1  EX controls, zero when `ex_valid`=0.
- `perf_bubbles`  out  PERF_W  saturating count of inserted bubbles.

## Operation
- Registered fields: valid, pc, rs1/rs2 data, imm, rs1/rs2/rd indices, alu_ctrl, alu_src_imm, and the four controls.
- Load-use hazard: `hz` = `ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))`.
- `stall_id` = `hz & ~flush`. The output is combinational.
- Capture rule per edge, in priority order:
  - `flush` → load bubble.
  - `hz` → load bubble.
  - Otherwise load the ID fields, with all controls ANDed with `id_valid`.
- A bubble sets valid and all four controls to 0 and `ex_alu_ctrl`=000. Data fields are don't-care.
- Forwarding, combinational on the registered indices. For operand X in {rs1, rs2}:
  - Rule 1: `exmem_reg_write & exmem_rd!=0 & exmem_rd==X` → `exmem_result`.
  - Rule 2: else `memwb_reg_write & memwb_rd!=0 & memwb_rd==X` → `memwb_data`.
  - Rule 3: else the registered register-file data.
  - Priority is rule 1 > rule 2 > rule 3.
- Operand routing:
  - `ex_alu_a` = forwarded rs1.
  - `ex_alu_b` = `alu_src_imm` ? imm : forwarded rs2.
  - `ex_store_data` = forwarded rs2 regardless of `alu_src_imm`.
- Register x0 is never a forwarding source.
- `perf_bubbles` increments on each edge where a hazard bubble is loaded. It saturates at all-ones. Flush bubbles are not counted.

## Timing
- Reset (asynchronous assert, synchronous-safe release): every register is 0.
  - `ex_valid`, controls, `ex_rd`, `ex_pc`, `ex_alu_ctrl`, `perf_bubbles` read 0.
  - With no forwarding hits, `ex_alu_a`/`ex_alu_b`/`ex_store_data` read 0.
  - `stall_id`=0.
- Reset mid-stall clears the bubble state immediately. No stall persists.
- Latency: an ID instruction appears on the `ex_*` outputs one cycle after the edge that captures it.
- A load-use stall lasts exactly one cycle. On the next cycle the load is in MEM/WB and is forwarded via rule 2.
- Simultaneous `flush` and `hz`: flush wins, `stall_id`=0, one bubble, not counted.
- `id_valid`=0: registers as a bubble and is never a hazard source.

## Test plan
- Reset: hold `rst_n`=0 mid-run with `ex_valid`=1 → all outputs 0 asynchronously, before the next edge.
- `add x3,x1,x2` then `sub x4,x3,x1`, with `exmem_rd`=3, `exmem_result`=0x10, `memwb_rd`=3, `memwb_data`=0x99 → `ex_alu_a`=0x10 (EX/MEM priority). With `exmem_rd`=0 → `ex_alu_a` = register-file data.
- `lw x5` in EX, ID `addi x6,x5,4` (`use_rs1`=1) → `stall_id`=1 for one cycle.
  - Next cycle: `ex_valid`=0 and `perf_bubbles`=1.
  - Following cycle: `ex_alu_a`=`memwb_data`=0xABCD, `ex_alu_b`=4.
- Load to x0 followed by a reader of x0 → `stall_id`=0, and no forwarding even when `exmem_rd`=0 with `exmem_reg_write`=1.
- `flush`=1 during a load-use hazard → `stall_id`=0, next `ex_valid`=0 with all controls 0, `perf_bubbles` unchanged.
- Store `sw x7,8(x2)` with `exmem_rd`=7, `exmem_result`=0x55 → `ex_store_data`=0x55, `ex_alu_b`=8. Preload `perf_bubbles` near all-ones and force hazards → it saturates at 0xFFFF.
